// File: rtl/cdim_pkg.sv
// cdim_pkg: shared types and constants for the fetch/decode instruction queue.
package cdim_pkg;
  localparam int INST_FIFO_DEPTH = 16;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fifo_entry_t;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} delay_state_t;
endpackage

// File: rtl/inst_fifo_ram.sv
// inst_fifo_ram: 2-write/2-read entry array, writes at wptr/wptr+1, reads at rptr/rptr+1.
module inst_fifo_ram
  import cdim_pkg::*;
#(
  parameter int DEPTH = INST_FIFO_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we1_i,
  input  logic             we2_i,
  input  logic [PTR_W-1:0] wptr_i,
  input  logic [PTR_W-1:0] rptr_i,
  input  fifo_entry_t      wdata1_i,
  input  fifo_entry_t      wdata2_i,
  output fifo_entry_t      rdata1_o,
  output fifo_entry_t      rdata2_o
);
  fifo_entry_t mem_q [DEPTH];
  logic [PTR_W-1:0] wptr2, rptr2;
  assign wptr2 = wptr_i + PTR_W'(1);
  assign rptr2 = rptr_i + PTR_W'(1);
  assign rdata1_o = mem_q[rptr_i];
  assign rdata2_o = mem_q[rptr2];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (we1_i) mem_q[wptr_i] <= wdata1_i;
      if (we2_i) mem_q[wptr2] <= wdata2_i;
    end
  end
endmodule

// File: rtl/inst_fifo.sv
// inst_fifo: dual-push/dual-pop fetch-to-decode queue that can hold a branch delay slot across a flush.
// Define INST_FIFO_BYPASS_EN to forward pushes straight to the read ports while the queue is empty.
module inst_fifo
  import cdim_pkg::*;
#(
  parameter int DEPTH = INST_FIFO_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fifo_rst,
  input  logic        delay_keep,
  input  logic        flush_delay_slot,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_inst2,
  input  logic [31:0] write_pc1,
  input  logic [31:0] write_pc2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic        full,
  output logic        master_valid,
  output logic        slave_valid,
  output logic [31:0] read_inst1,
  output logic [31:0] read_inst2,
  output logic [31:0] read_pc1,
  output logic [31:0] read_pc2,
  output logic        master_is_in_delayslot
);
  localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);
  localparam logic [PTR_W:0] CNT_HIGH = (PTR_W+1)'(DEPTH - 2);
  delay_state_t state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0] count_q, count_d, n_push, n_pop;
  fifo_entry_t delay_q, delay_d, head1, head2, wr1, wr2;
  logic push1, push2, bypass, hold, idle, ge2;
  assign wr1 = {write_inst1, write_pc1};
  assign wr2 = {write_inst2, write_pc2};
  assign hold = state_q == HOLD;
  assign idle = state_q == IDLE;
  assign ge2 = count_q >= CNT_TWO;
  assign full = count_q > CNT_HIGH;
  assign push1 = write_en1 & ~full;
  assign push2 = push1 & write_en2;
`ifdef INST_FIFO_BYPASS_EN
  assign bypass = idle & (count_q == '0);
`else
  assign bypass = 1'b0;
`endif
  assign master_valid = hold | (idle & (bypass ? push1 : count_q != '0));
  assign slave_valid = idle & (bypass ? push2 : ge2);
  assign master_is_in_delayslot = hold;
  assign {read_inst1, read_pc1} = hold ? delay_q : bypass ? wr1 : head1;
  assign {read_inst2, read_pc2} = bypass ? wr2 : head2;
  // In WAIT the first pushed entry goes to the delay register and the rest is dropped.
  assign n_push = state_q == WAIT ? '0 : (PTR_W+1)'(push1) + (PTR_W+1)'(push2);
  assign n_pop = (idle & read_en1 & master_valid) ? (PTR_W+1)'(1) + (PTR_W+1)'(read_en2 & slave_valid) : '0;
  inst_fifo_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk(clk), .resetn(resetn), .we1_i(push1), .we2_i(push2), .wptr_i(wptr_q), .rptr_i(rptr_q),
    .wdata1_i(wr1), .wdata2_i(wr2), .rdata1_o(head1), .rdata2_o(head2)
  );
  always_comb begin
    state_d = (hold & read_en1) ? IDLE : state_q;
    delay_d = delay_q;
    wptr_d = wptr_q + PTR_W'(n_push);
    rptr_d = rptr_q + PTR_W'(n_pop);
    count_d = count_q + n_push - n_pop;
    if (flush_delay_slot | fifo_rst) begin
      wptr_d = wptr_q;
      rptr_d = wptr_q;
      count_d = '0;
    end
    if (flush_delay_slot) state_d = IDLE;
    else if (fifo_rst & delay_keep) begin
      state_d = ge2 ? HOLD : WAIT;
      delay_d = ge2 ? head2 : delay_q;
    end else if (~fifo_rst & (state_q == WAIT) & push1) begin
      state_d = HOLD;
      delay_d = wr1;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      delay_q <= delay_d;
    end
  end
endmodule
